// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: owns the PC, selects the next PC from ID's branch bus,
// drives the instruction SRAM and keeps ID's instruction word stable across ID stalls.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic [31:0] if_inst,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  localparam logic STOP = 1'b1;

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] next_pc;

  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic        id_ce_q, id_ce_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_v_q, hold_v_d;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign next_pc = br_e ? br_addr : pc_q + 32'h4;

  always_comb begin
    pc_d     = pc_q;
    ce_d     = ce_q;
    id_ce_d  = id_ce_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;

    // A stalled PC ignores br_bus; ID re-resolves the branch once released.
    if (stall[0] != STOP) begin
      pc_d = next_pc;
      ce_d = 1'b1;
    end

    if (stall[1] == STOP && stall[2] != STOP) begin
      id_ce_d = 1'b0;
    end else if (stall[1] != STOP) begin
      id_ce_d = ce_q;
    end

    // On the first ID-stall cycle the SRAM still returns ID's word; capture it
    // before the SRAM starts re-reading pc_q (IF's instruction).
    if (stall[1] != STOP) begin
      hold_v_d = 1'b0;
    end else if (!hold_v_q) begin
      hold_d   = inst_sram_rdata;
      hold_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ce_q     <= 1'b0;
      id_ce_q  <= 1'b0;
      hold_q   <= 32'h0;
      hold_v_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ce_q     <= ce_d;
      id_ce_q  <= id_ce_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
    end
  end

  assign if_inst         = !id_ce_q ? 32'h0 : (hold_v_q ? hold_q : inst_sram_rdata);
  assign if_to_id_bus    = {ce_q, pc_q};
  assign inst_sram_en    = ce_q;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wdata = 32'h0;

endmodule
